adder_arbiter: RTL
==================

# adder_arbiter

Shares one combinational adder (structural or behavioral, instantiated outside this block) between two requesters. Each requester has a valid/ready request channel carrying two operands and a valid/ready response channel returning the full-width sum. A three-state FSM sequences accepted requests through the adder. Round-robin selection gives fair access when both requesters contend. The block sits between test or user logic and a single adder instance in the top level.

## Interface

- WIDTH, 14, operand width; sum width is WIDTH+1

- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operand pair
- req0_ready  output  1  block accepts requester 0's request this cycle
- req0_a, req0_b  input  WIDTH  requester 0 operands
- rsp0_valid  output  1  sum for requester 0 available
- rsp0_ready  input  1  requester 0 consumes the response
- rsp0_sum  output  WIDTH+1  result for requester 0
- req1_valid, req1_ready, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_sum: same as above, for requester 1
- adder_a, adder_b  output  WIDTH  operands driven to the shared adder
- adder_sum  input  WIDTH+1  shared adder output (combinational from adder_a/adder_b)
- busy  output  1  high whenever the FSM is not in IDLE
- op_count  output  8  completed operations, wraps 255 -> 0

## Operation

- FSM states are IDLE, CALC and RESP.
- **Selection in IDLE:**
  - grant = 0 if only req0_valid is high.
  - grant = 1 if only req1_valid is high.
  - If both are high, grant = the requester that is not last_grant.
- **Ready:** reqN_ready = (state==IDLE) && reqN_valid && (grant==N). It is combinational, at most one is high, and both are low outside IDLE.
- **IDLE -> CALC:** on reqN_valid && reqN_ready:
  - latch op_a <= reqN_a and op_b <= reqN_b;
  - set owner <= N.
- **CALC -> RESP:** unconditional after one cycle; sum_reg <= adder_sum.
- **RESP:**
  - rsp{owner}_valid = 1; the other requester's rsp_valid stays 0.
  - Both rspN_sum outputs are driven from sum_reg.
  - On rsp{owner}_ready: last_grant <= owner, op_count <= op_count+1, go to IDLE.
- **Operand hold:** adder_a = op_a and adder_b = op_b at all times, so they stay stable from CALC through RESP.
- **Arithmetic:** the sum is WIDTH+1 bits with no truncation. adder_sum is captured unmodified; the block does no checking of its own.
- **Requester rules:** a requester holds valid and operands stable until ready. A request whose valid drops before ready is simply never accepted.
- **Reset values:**
  - state = IDLE, last_grant = 1 (requester 0 wins the first contention), owner = 0;
  - op_a = op_b = 0, sum_reg = 0, op_count = 0;
  - all rsp_valid = 0, busy = 0.
- **Reset mid-operation:** the in-flight request is dropped and no response is issued. op_count is cleared.

## Timing

- Request accepted at edge k: CALC occupies cycle k..k+1, sum_reg is loaded at edge k+1, and rspN_valid is high from edge k+1.
- The adder has one full clock period to settle.
- If rspN_ready is already high when RESP is entered, the response completes at edge k+2 and IDLE can accept a new request in cycle k+2.
- Minimum spacing is one request per 3 cycles. Back-to-back contention alternates 0,1,0,1.
- rsp_valid is held while rsp_ready is low; sum_reg and the adder operands do not change while RESP waits.
- op_count increments on the same edge as the response handshake.
- busy = (state != IDLE) is combinational from the state register.

## Test plan

- **Single request:** after reset, req0 = (a=5, b=7) with rsp0_ready=1.
  - Expect req0_ready in the same cycle.
  - Expect rsp0_valid two edges later with rsp0_sum=12, and op_count=1.
- **Full-width carry:** req1 = (16383, 16383).
  - Expect rsp1_sum=32766 (15 bits, no truncation).
  - rsp0_valid stays 0 throughout.
- **Contention:** both valid continuously, rsp_ready=1 on both.
  - Grants are 0,1,0,1 on accept edges spaced exactly 3 cycles apart.
  - op_count=4 after four responses.
- **Backpressure:** req0 = (100, 23), rsp0_ready held low 5 cycles.
  - rsp0_valid stays 1 with rsp0_sum=123; adder_a/b stay 100/23.
  - req1_ready stays 0 even with req1_valid high.
  - On rsp0_ready, return to IDLE and grant req1 next cycle.
- **Reset mid-op:** assert rst during CALC for req0 = (1, 2).
  - All outputs return to reset values asynchronously.
  - No rsp0_valid occurs afterward, and op_count=0.
- **Wrap:** complete 256 single requests.
  - op_count reads 0 after the 256th handshake and busy=0 in IDLE.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external combinational adder between two valid/ready requesters.
// Latency: accept edge k -> response valid from edge k+1; a response held without rsp_ready stalls the block in RESP.
module adder_arbiter #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH:0]   rsp0_sum,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH:0]   rsp1_sum,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  input  logic [WIDTH:0]   adder_sum,
  output logic             busy,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state_q;
  logic             last_grant_q;
  logic             owner_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH:0]   sum_q;
  logic [7:0]       op_count_q;
  logic             rsp0_valid_q;
  logic             rsp1_valid_q;
  logic             grant_d;
  logic             accept;
  logic             rsp_done;

  // On contention the requester that did not win last time gets the adder.
  always_comb begin
    grant_d = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_d = ~last_grant_q;
    end else if (req1_valid) begin
      grant_d = 1'b1;
    end
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !grant_d;
  assign req1_ready = (state_q == IDLE) && req1_valid &&  grant_d;
  assign accept     = req0_ready || req1_ready;
  assign rsp_done   = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      sum_q        <= '0;
      op_count_q   <= 8'd0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_a_q  <= grant_d ? req1_a : req0_a;
            op_b_q  <= grant_d ? req1_b : req0_b;
            owner_q <= grant_d;
            state_q <= CALC;
          end
        end
        CALC: begin
          sum_q        <= adder_sum;
          rsp0_valid_q <= !owner_q;
          rsp1_valid_q <= owner_q;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            last_grant_q <= owner_q;
            op_count_q   <= op_count_q + 8'd1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_sum   = sum_q;
  assign rsp1_sum   = sum_q;
  assign adder_a    = op_a_q;
  assign adder_b    = op_b_q;
  assign busy       = (state_q != IDLE);
  assign op_count   = op_count_q;

endmodule
